// File: rtl/bus_decoder.sv
// Address decoder/interconnect between the CPU memory port and N memory-mapped slaves.
// Requests are registered to one slave; unmapped or hung accesses finish with a bus error.
module bus_decoder #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SEL_MSB  = 31,
  parameter int SEL_LSB  = 28,
  parameter logic [N_SLAVES*(SEL_MSB-SEL_LSB+1)-1:0] SLAVE_IDS = {4'h6, 4'h5, 4'h4, 4'h0},
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       m_valid,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wstrb,
  output logic                       m_ready,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_err,
  output logic [N_SLAVES-1:0]        s_valid,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_wstrb,
  input  logic [N_SLAVES-1:0]        s_ready,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  output logic [ADDR_W-1:0]          err_addr,
  output logic [1:0]                 err_cause
);

  localparam int SEL_W = SEL_MSB - SEL_LSB + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

  // Handshake: the master holds m_valid with stable m_addr/m_wdata/m_wstrb until an
  // edge in IDLE accepts it; completion is the single-cycle m_ready pulse. Each slave
  // sees s_valid[i] held with stable s_* buses until it returns s_ready[i] at an edge.
  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic [N_SLAVES-1:0] match_oh;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;
  logic                timeout;

  // Iterating from the top index down lets the lowest matching slave win.
  always_comb begin
    match_oh = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (m_addr[SEL_MSB:SEL_LSB] == SLAVE_IDS[i*SEL_W +: SEL_W]) begin
        match_oh    = '0;
        match_oh[i] = 1'b1;
      end
    end
  end

  // s_valid doubles as the latched one-hot select while BUSY.
  always_comb begin
    sel_ready = |(s_ready & s_valid);
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (s_valid[i]) sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
    end
    timeout = (cnt == CNT_W'(TIMEOUT));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (m_valid) state_n = (|match_oh) ? BUSY : ERR;
      BUSY: begin
        if (sel_ready)    state_n = RESP;
        else if (timeout) state_n = ERR;
      end
      RESP:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      m_ready   <= 1'b0;
      m_err     <= 1'b0;
      m_rdata   <= '0;
      s_valid   <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      err_addr  <= '0;
      err_cause <= 2'b00;
    end else begin
      state   <= state_n;
      m_ready <= (state_n == RESP) || (state_n == ERR);
      m_err   <= (state_n == ERR);
      m_rdata <= (state == BUSY && sel_ready) ? sel_rdata : '0;
      case (state)
        IDLE: begin
          if (m_valid) begin
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_wstrb <= m_wstrb;
            s_valid <= match_oh;
            cnt     <= '0;
            if (match_oh == '0) begin
              err_addr  <= m_addr;
              err_cause <= 2'b01;
            end
          end
        end
        BUSY: begin
          if (sel_ready) begin
            s_valid <= '0;
          end else if (timeout) begin
            s_valid   <= '0;
            err_addr  <= s_addr;
            err_cause <= 2'b10;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: s_valid <= '0;
      endcase
    end
  end

endmodule
